// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads, two write ports, register 0 tied to zero,
// background scrub sequencer. Define REGFILE_BYPASS_EN for write-first forwarding onto the read ports.
module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 3
) (
    input  logic                       CLK,
    input  logic                       Reset_n,
    input  logic [NUM_RD*ADDR_W-1:0]   nR,
    output logic [NUM_RD*DATA_W-1:0]   R,
    input  logic [ADDR_W-1:0]          nD0,
    input  logic [ADDR_W-1:0]          nD1,
    input  logic [DATA_W-1:0]          D0,
    input  logic [DATA_W-1:0]          D1,
    input  logic                       WE0,
    input  logic                       WE1,
    input  logic                       Clear,
    output logic                       Busy,
    output logic                       Done,
    output logic                       state_dbg
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } scrub_state_t;

    scrub_state_t        state;
    scrub_state_t        state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   ptr_nxt;
    logic                done_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   rd_sel;
    logic [DATA_W-1:0]   rd_val;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (Clear) begin
                    state_nxt = SCRUB;
                    ptr_nxt   = ADDR_W'(1);
                end
            end
            SCRUB: begin
                if (ptr == LAST) begin
                    done_nxt = 1'b1;
                    // The final scrub edge is also the first IDLE sampling point, so a held
                    // Clear restarts immediately with Done and Busy overlapping.
                    if (Clear) begin
                        state_nxt = SCRUB;
                        ptr_nxt   = ADDR_W'(1);
                    end else begin
                        state_nxt = IDLE;
                        ptr_nxt   = '0;
                    end
                end else begin
                    ptr_nxt = ptr + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state <= IDLE;
            ptr   <= '0;
            Done  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            Done  <= done_nxt;
        end
    end

    // Priority per register: reset, port 1, port 0, scrub zeroing.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!Reset_n || i == 0) begin
                mem[i] <= '0;
            end else if (WE1 && nD1 == ADDR_W'(i)) begin
                mem[i] <= D1;
            end else if (WE0 && nD0 == ADDR_W'(i)) begin
                mem[i] <= D0;
            end else if (state == SCRUB && ptr == ADDR_W'(i)) begin
                mem[i] <= '0;
            end
        end
    end

    always_comb begin
        R      = '0;
        rd_sel = '0;
        rd_val = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_sel = nR[k*ADDR_W +: ADDR_W];
            rd_val = (rd_sel == '0) ? '0 : mem[rd_sel];
`ifdef REGFILE_BYPASS_EN
            if (rd_sel != '0) begin
                if (WE1 && nD1 == rd_sel) begin
                    rd_val = D1;
                end else if (WE0 && nD0 == rd_sel) begin
                    rd_val = D0;
                end
            end
`endif
            R[k*DATA_W +: DATA_W] = rd_val;
        end
    end

    assign Busy      = (state == SCRUB);
    assign state_dbg = (state == SCRUB);

endmodule
